// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the instruction fetch stage |
// | Revision  : 1.0                                                        |
// +----------------------------------------------------------------------+
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_HOLD   = 3'd2,
    ST_HALTED = 3'd3,
    ST_ERROR  = 3'd4
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam int unsigned CNT_WIDTH   = 8;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch_if : memory and control_unit bus of the fetch stage |
// | Revision             : 1.0                                            |
// +----------------------------------------------------------------------+
interface instruction_fetch_if #(
  parameter int SIZE     = 32,
  parameter int PC_WIDTH = 32
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [SIZE-1:0]     imem_data;
  logic [SIZE-1:0]     instruction;
  logic                instr_valid;
  logic                instr_taken;
  logic                branch_en;
  logic [PC_WIDTH-1:0] branch_target;
  logic                halt;

  modport master (
    output imem_req, imem_addr, instruction, instr_valid,
    input  imem_ack, imem_data, instr_taken, branch_en, branch_target, halt
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_valid,
    output imem_ack, imem_data, instr_taken, branch_en, branch_target, halt
  );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pc_reg : program counter with sequential/branch next-PC mux      |
// | Revision     : 1.0                                                     |
// +----------------------------------------------------------------------+
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                load_i,
  input  wire logic                branch_en_i,
  input  wire logic [PC_WIDTH-1:0] branch_target_i,
  output logic      [PC_WIDTH-1:0] pc_o
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] branch_pc;
  logic [1:0]          unused_target_lsbs;

  // Sequential add wraps naturally at 2^PC_WIDTH; branch targets are word-aligned.
  assign seq_pc             = pc_q + PC_WIDTH'(INSTR_BYTES);
  assign branch_pc          = {branch_target_i[PC_WIDTH-1:2], 2'b00};
  assign unused_target_lsbs = branch_target_i[1:0];

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = branch_en_i ? branch_pc : seq_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch : PC owner, req/ack fetch FSM and instruction reg    |
// | Revision          : 1.0                                                |
// +----------------------------------------------------------------------+
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                  SIZE     = 32,
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned         TIMEOUT  = 15
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  instruction_fetch_if.master       bus,
  output logic      [PC_WIDTH-1:0]  pc_o,
  output logic                      fetch_error_o
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);

  fetch_state_e         state_q;
  fetch_state_e         state_d;
  logic [CNT_WIDTH-1:0] wait_cnt_q;
  logic [CNT_WIDTH-1:0] wait_cnt_d;
  logic [SIZE-1:0]      instr_q;
  logic [SIZE-1:0]      instr_d;
  logic                 pc_load;
  logic [PC_WIDTH-1:0]  pc;

  fetch_pc_reg #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst             (rst),
    .load_i          (pc_load),
    .branch_en_i     (bus.branch_en),
    .branch_target_i (bus.branch_target),
    .pc_o            (pc)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    instr_d    = instr_q;
    pc_load    = 1'b0;
    case (state_q)
      ST_RESET: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Ack wins even on the last permitted wait cycle.
        if (bus.imem_ack) begin
          instr_d    = bus.imem_data;
          wait_cnt_d = '0;
          state_d    = ST_HOLD;
        end else if (wait_cnt_q >= TIMEOUT_CNT) begin
          state_d = ST_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.instr_taken) begin
          pc_load = 1'b1;
          state_d = bus.halt ? ST_HALTED : ST_FETCH;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RESET;
      wait_cnt_q <= '0;
      instr_q    <= SIZE'(NOP_INSTR);
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      instr_q    <= instr_d;
    end
  end

  assign bus.imem_req    = (state_q == ST_FETCH);
  assign bus.imem_addr   = pc;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = (state_q == ST_HOLD);
  assign pc_o            = pc;
  assign fetch_error_o   = (state_q == ST_ERROR);

endmodule
`default_nettype wire
